// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types for the shift-add multiplier
package mul_pkg;

  // Multiplier control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-add multiplier, one step per cycle (MUL_SIGNED_EN selects two's complement operands)
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               EA,
  input  logic               EB,
  input  logic [WIDTH-1:0]   Data,
  input  logic               Start,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Q,
  output logic               Busy,
  output logic               Done
);

  // Step counter runs 0..WIDTH-1; the last value marks the final step.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_t         state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] q_reg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] sum;
  logic [2*WIDTH-1:0] product;

  // Accumulator plus the current partial product (multiplicand if LSB of multiplier set).
  assign sum = acc + (mplier[0] ? mcand : '0);

`ifdef MUL_SIGNED_EN
  logic neg;
  logic neg_start;

  // Work on magnitudes; the most negative value maps to its own bit pattern, which is the correct magnitude.
  assign op_a      = a_reg[WIDTH-1] ? -a_reg : a_reg;
  assign op_b      = b_reg[WIDTH-1] ? -b_reg : b_reg;
  assign neg_start = a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
  assign product   = neg ? -sum : sum;

  // Remember the result sign captured at Start so the magnitude can be negated on completion.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      neg <= 1'b0;
    end else if (state != CALC && Start) begin
      neg <= neg_start;
    end
  end
`else
  assign op_a    = a_reg;
  assign op_b    = b_reg;
  assign product = sum;
`endif

  // Control FSM with operand loading, shift-add datapath and result capture.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      q_reg  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (EA) a_reg <= Data;
          if (EB) b_reg <= Data;
          if (Start) begin
            // op_a/op_b come from the registers before this edge's loads.
            state  <= CALC;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, op_a};
            mplier <= op_b;
            cnt    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            q_reg <= product;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign A    = a_reg;
  assign B    = b_reg;
  assign Q    = q_reg;
  assign Busy = (state == CALC);
  assign Done = (state == DONE);

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 SHALL have port Clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port Rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port EA, input, 1: load Data into operand register A.
REQ-005 SHALL have port EB, input, 1: load Data into operand register B.
REQ-006 SHALL have port Data, input, WIDTH: operand load bus.
REQ-007 SHALL have port Start, input, 1: request a multiply of the current A and B.
REQ-008 SHALL have port A, output, WIDTH: operand register A contents.
REQ-009 SHALL have port B, output, WIDTH: operand register B contents.
REQ-010 SHALL have port Q, output, 2*WIDTH: product of the last completed multiply.
REQ-011 SHALL have port Busy, output, 1: high while a multiply is in progress.
REQ-012 SHALL have port Done, output, 1: one-cycle pulse when Q has just been updated.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-014 In IDLE or DONE, EA and EB SHALL load Data on the clock edge; EA and EB high together SHALL load both registers.
REQ-015 In CALC, EA and EB SHALL be ignored, so A and B stay frozen.
REQ-016 Start sampled in IDLE or DONE SHALL go to CALC, using A and B as they were before that edge, even if EA or EB loads on the same edge.
REQ-017 Start sampled in CALC SHALL be ignored, and no request SHALL be queued.
REQ-018 CALC SHALL perform exactly one shift-add step per cycle, WIDTH steps in total, using an internal accumulator and counter.
REQ-019 On the edge of step WIDTH, the FSM SHALL enter DONE and Q SHALL take the full 2*WIDTH product; no truncation, no overflow possible.
REQ-020 Q SHALL hold its previous value throughout CALC and change only on entry to DONE.
REQ-021 Busy SHALL be 1 exactly in CALC; Done SHALL be 1 exactly in DONE.
REQ-022 Latency SHALL be WIDTH cycles from the Start edge to the Done pulse.
REQ-023 DONE without Start SHALL return to IDLE on the next edge.
REQ-024 DONE with Start SHALL enter CALC directly, giving back-to-back operation.
REQ-025 Operand values 0 and all-ones SHALL need no special case; the latency SHALL be identical for them.

Reset
REQ-026 Rst high SHALL set the FSM to IDLE and clear A, B, Q, the accumulator and the counter; Busy and Done SHALL be 0.
REQ-027 Rst SHALL take priority over Start, EA and EB on the same edge.
REQ-028 Rst during CALC SHALL abort the multiply; Done SHALL NOT pulse, and Q SHALL read 0.

Configuration
REQ-029 The macro MUL_SIGNED_EN SHALL select the operand interpretation at compile time.
REQ-030 With MUL_SIGNED_EN defined, A, B and Q SHALL be two's complement.
- Operands are converted to magnitude at Start.
- The product is negated at completion if the operand signs differ.
- Latency is unchanged.
- -2^(WIDTH-1) * -2^(WIDTH-1) SHALL give +2^(2*WIDTH-2).
REQ-031 Without MUL_SIGNED_EN, all operands and Q SHALL be unsigned.

Structure
REQ-032 The FSM state typedef (IDLE/CALC/DONE) SHALL live in the shared package mul_pkg.
REQ-033 The step-counter width constant, derived from WIDTH, SHALL be local to the module.
REQ-034 The block SHALL be a single module with no sub-module; display decoding stays in the top level.

Verification
REQ-035 WIDTH=8, A=0xFF, B=0xFF, Start -> Busy for 8 cycles, then Done=1 for 1 cycle with Q=0xFE01.
REQ-036 WIDTH=8, A=0x00, B=0xA5 -> Q=0x0000 after 8 cycles; a preceding Q=0xFE01 is held throughout CALC.
REQ-037 Start again at cycle 3 of CALC, plus EA=1 with Data=0x11 -> both ignored; A unchanged; Done exactly once.
REQ-038 Rst at cycle 4 of CALC -> next cycle IDLE, Q=0, A=0, B=0, no Done pulse.
REQ-039 WIDTH=4, A=0xF, B=0xF -> Q=0xE1 after 4 cycles; Start held through DONE starts a second multiply at once.
REQ-040 MUL_SIGNED_EN, WIDTH=8, A=0xFD (-3), B=0x05 -> Q=0xFFF1 (-15); A=0x80, B=0x80 -> Q=0x4000.
